multu_hilo_unit: RTL and testbench

- Iterative unsigned 32x32 multiplier with architectural HI/LO registers; sits directly downstream of the instruction decoder in the MIPS datapath.
- Started when the decoder classifies an instruction as MULTU (R-type, funct 011001).
- Feeds MFHI/MFLO results (funct 010000 / 010010) back into the register-file write-back mux.
- Raises a stall so the PC and register file hold while the multiply iterates.

---
 rtl/multu_hilo_unit.sv | 120 ++++++++++++
 tb/tb_multu_hilo_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/multu_hilo_unit.sv
// Iterative unsigned WIDTH x WIDTH multiplier with architectural HI/LO registers.
// One shift-add step per clock; the datapath is stalled while the product is formed.
module multu_hilo_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hilo_sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [CNTW-1:0] LastCnt = CNTW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // Product register: upper WIDTH+1 bits accumulate (with carry), lower WIDTH bits hold
  // the not-yet-consumed multiplier bits and receive the low product bits as they shift in.
  logic [2*WIDTH:0]   p_q, p_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     acc_sum;
  logic [2*WIDTH:0]   p_step;

  // One shift-add iteration of the product register.
  always_comb begin
    acc_sum = p_q[2*WIDTH:WIDTH];
    if (p_q[0]) begin
      acc_sum = p_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    end
    p_step = {1'b0, acc_sum, p_q[WIDTH-1:1]};
  end

  // Next-state logic: accept in idle, iterate in run, commit HI/LO on the last step.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = srca;
          p_d     = {{(WIDTH+1){1'b0}}, srcb};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        // start is ignored here: the stalled instruction keeps it asserted.
        p_d   = p_step;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == LastCnt) begin
          hi_d    = p_step[2*WIDTH-1:WIDTH];
          lo_d    = p_step[WIDTH-1:0];
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any partial product immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Outputs: stall covers the accepting cycle before busy rises.
  always_comb begin
    hi       = hi_q;
    lo       = lo_q;
    busy     = busy_q;
    done     = done_q;
    stall    = busy_q | (start & ~busy_q);
    hilo_out = hilo_sel ? hi_q : lo_q;
  end

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Scoreboard bench for multu_hilo_unit: driver pushes expected products, monitor
// pops and compares on every done pulse.
module tb_multu_hilo_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        hilo_sel = 1'b0;
  logic [31:0] hilo_out, hi, lo;
  logic        busy, stall, done;

  multu_hilo_unit #(.WIDTH(32), .CNTW(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .srca     (srca),
    .srcb     (srcb),
    .hilo_sel (hilo_sel),
    .hilo_out (hilo_out),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall),
    .done     (done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] sb_q[$];
  logic [31:0] arch_hi = '0;
  logic [31:0] arch_lo = '0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding product.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (done === 1'b1) begin
        check("done_has_pending_op", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp = sb_q.pop_front();
          check("hi", hi, exp[63:32]);
          check("lo", lo, exp[31:0]);
          check("hilo_out", hilo_out, hilo_sel ? exp[63:32] : exp[31:0]);
          arch_hi = exp[63:32];
          arch_lo = exp[31:0];
        end
      end
    end
  end

  // Issue one MULTU. hold keeps start high until completion; srcb is changed to chg_val
  // at RUN cycle chg_cycle; abort_cycle >= 0 pulls reset mid-run between edges.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit hold,
                        input int chg_cycle, input logic [31:0] chg_val,
                        input int abort_cycle);
    int stall_cycles;
    @(negedge clk);
    srca  = a;
    srcb  = b;
    start = 1'b1;
    sb_q.push_back(64'(a) * 64'(b));
    stall_cycles = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!stall) break;
      stall_cycles++;
      if (c == 0) check("start_cycle_busy", 32'(busy), 32'd0);
      if (c >= 1 && busy) begin
        // HI/LO must keep their previous architectural values while iterating.
        check("run_hold_hi", hi, arch_hi);
        check("run_hold_lo", lo, arch_lo);
        check("run_hold_hilo_out", hilo_out, hilo_sel ? arch_hi : arch_lo);
      end
      @(posedge clk);
      #1;
      if (!hold || !busy) start = 1'b0;
      if (c == chg_cycle) srcb = chg_val;
      srca     = $urandom;
      hilo_sel = 1'($urandom_range(0, 1));
      if (c == abort_cycle) begin
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        void'(sb_q.pop_back());
        arch_hi = '0;
        arch_lo = '0;
        start   = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("stall_cycles", 32'(stall_cycles), 32'd33);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(32'd3, 32'd5, 1'b0, -1, '0, -1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1, '0, -1);
    @(posedge clk);
    #1;
    hilo_sel = 1'b1;
    #1;
    check("max_hilo_out_hi", hilo_out, 32'hFFFF_FFFE);
    hilo_sel = 1'b0;
    #1;
    check("max_hilo_out_lo", hilo_out, 32'h0000_0001);

    run_op(32'h0001_0000, 32'h0001_0000, 1'b0, -1, '0, -1);
    run_op(32'd0, 32'h1234, 1'b0, -1, '0, -1);
    // Held start with srcb disturbed mid-run: no restart, operands latched at acceptance.
    run_op(32'd2, 32'd9, 1'b1, 10, 32'd7, -1);
    repeat (3) @(negedge clk);
    run_op(32'd6, 32'd7, 1'b0, -1, '0, -1);
    run_op(32'h100, 32'h100, 1'b0, -1, '0, -1);

    for (int i = 0; i < 6; i++) begin
      run_op($urandom, $urandom, 1'b0, -1, '0, -1);
    end

    // Asynchronous reset in the middle of an operation.
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, -1, '0, 15);
    repeat (2) @(negedge clk);
    check("post_abort_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    run_op(32'd4, 32'd4, 1'b0, -1, '0, -1);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
